apu_reg_file: RTL and testbench
===============================

APU_REG_FILE -- requirements
Module: apu_reg_file

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  system clock (4194304 Hz); all state updates on posedge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 wr  in  1  write strobe; one write per cycle.
REQ-005 rd  in  1  read strobe.
REQ-006 addr  in  8  low byte of register address 0xFFxx.
REQ-007 wdata  in  8  write data.
REQ-008 rdata  out  8  registered read data.
REQ-009 ch_on  in  4  channel-active status {noise, wave, sq2, sq1} from the channels.
REQ-010 sq1 fields  out  swpPd 3, negate 1, shift 3, duty 2, lenLoad 6, startVol 4, envAdd 1, period 3, freq 11, lenEnable 1, trig 1.
REQ-011 sq2 fields  out  duty 2, lenLoad 6, startVol 4, envAdd 1, period 3, freq 11, lenEnable 1, trig 1.
REQ-012 w fields  out  enable 1, vol 2, lenLoad 6, freq 11, lenEnable 1, trig 1.
REQ-013 n fields  out  lenLoad 6, startVol 4, envAdd 1, period 3, clkShift 4, widthMode 1, divisor 3, lenEnable 1, trig 1.
REQ-014 nr50  out  8; nr51  out  8: mixer volume and panning, raw register value.
REQ-015 wave_table  out  128; sample i at bits [4i+3:4i], i = 0..31.

Function
REQ-016 Map: 10 NR10 -PPP NSSS (swpPd, negate, shift); 11 NR11 DDLLLLLL; 12 NR12 VVVV APPP; 13 NR13 freq[7:0]; 14 NR14 T L--- -FFF (trig, lenEnable, freq[10:8]).
REQ-017 Map: 16–19 NR21–24 as NR11–14 for sq2; 1A NR30 bit7 enable; 1B NR31 lenLoad = wdata[5:0]; 1C NR32 vol = bits[6:5]; 1D/1E NR33/34 as NR13/14.
REQ-018 Map: 20 NR41 lenLoad = wdata[5:0]; 21 NR42 as NR12; 22 NR43 SSSS WDDD (clkShift, widthMode, divisor); 23 NR44 bits 7,6 only; 24 NR50; 25 NR51; 26 NR52 bit7 = power.
REQ-019 Wave RAM 30–3F: byte k writes sample 2k = wdata[7:4], sample 2k+1 = wdata[3:0].
REQ-020 Field outputs update on the posedge capturing the write; visible the following cycle.
REQ-021 Write to NRx4 with bit7 = 1 pulses that channel's trig high for exactly one cycle, the cycle in which the new freq/lenEnable are first visible.
REQ-022 NRx4 write with bit7 = 0 updates fields only; trig stays 0; back-to-back trigger writes give one pulse per write.
REQ-023 Read latency one cycle: rd at edge N -> rdata valid after edge N, held until next rd.
REQ-024 Read value = stored bits OR mask: NR10 80, NR11/21 3F, NR12/22/42/43/50/51 00, NR13/23/33 FF, NRx4 BF, NR30 7F, NR31 FF, NR32 9F, NR41 FF.
REQ-025 NR52 read = {power, 3'b111, ch_on}; wave RAM reads back raw bytes; unmapped addresses (15, 1F, 27–2F, others) read FF.
REQ-026 rd and wr to same address in one cycle: rdata returns the pre-write value.
REQ-027 NR52 write bit7 = 0: next edge clears all 10–25 registers and all field outputs to 0; no trig issued.
REQ-028 While power = 0: writes to 10–25 ignored; NR52 and wave RAM remain writable and readable.
REQ-029 NR52 write bit7 = 1 sets power; registers remain 0 until rewritten; bits 6:0 of NR52 writes ignored.

Reset
REQ-030 rst asserted: immediately all registers, field outputs, trigs, nr50, nr51, rdata = 0, wave_table = 0, power = 1.
REQ-031 rst deassertion mid-operation: no trig pulses for writes in flight; first write accepted on first edge with rst low.

Verification
REQ-032 Write 14 <= 0x87 after 13 <= 0x50 -> sq1_freq = 0x750, sq1_lenEnable = 0, sq1_trig high exactly 1 cycle.
REQ-033 Write 22 <= 0xA5, then rd 22 -> n_clkShift = 10, widthMode = 0, divisor = 5; rdata = 0xA5 next cycle.
REQ-034 Write 30 <= 0x1F -> wave_table[3:0] = 1, [7:4] = F; rd 30 -> 0x1F; rd 15 -> 0xFF.
REQ-035 ch_on = 4'b0101, write 26 <= 0x00, write 12 <= 0xF0 -> all fields 0, sq1_startVol stays 0, rd 26 -> 0x75.
REQ-036 rst pulsed mid-stream after setting NR50 = 0x77 -> nr50 = 0, rdata = 0, power = 1, no trig.

Source files
------------

// File: rtl/apu_reg_file.sv
// APU register file: decodes CPU writes to 0xFF10-0xFF3F into per-channel
// field outputs, one-cycle trigger pulses, mixer registers and wave RAM, and
// returns masked register contents on a registered read port.
module apu_reg_file (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic         rd,
  input  logic [7:0]   addr,
  input  logic [7:0]   wdata,
  output logic [7:0]   rdata,
  input  logic [3:0]   ch_on,
  // square 1
  output logic [2:0]   sq1_swpPd,
  output logic         sq1_negate,
  output logic [2:0]   sq1_shift,
  output logic [1:0]   sq1_duty,
  output logic [5:0]   sq1_lenLoad,
  output logic [3:0]   sq1_startVol,
  output logic         sq1_envAdd,
  output logic [2:0]   sq1_period,
  output logic [10:0]  sq1_freq,
  output logic         sq1_lenEnable,
  output logic         sq1_trig,
  // square 2
  output logic [1:0]   sq2_duty,
  output logic [5:0]   sq2_lenLoad,
  output logic [3:0]   sq2_startVol,
  output logic         sq2_envAdd,
  output logic [2:0]   sq2_period,
  output logic [10:0]  sq2_freq,
  output logic         sq2_lenEnable,
  output logic         sq2_trig,
  // wave
  output logic         w_enable,
  output logic [1:0]   w_vol,
  output logic [5:0]   w_lenLoad,
  output logic [10:0]  w_freq,
  output logic         w_lenEnable,
  output logic         w_trig,
  // noise
  output logic [5:0]   n_lenLoad,
  output logic [3:0]   n_startVol,
  output logic         n_envAdd,
  output logic [2:0]   n_period,
  output logic [3:0]   n_clkShift,
  output logic         n_widthMode,
  output logic [2:0]   n_divisor,
  output logic         n_lenEnable,
  output logic         n_trig,
  // mixer and wave RAM
  output logic [7:0]   nr50,
  output logic [7:0]   nr51,
  output logic [127:0] wave_table
);

  localparam int NREGS = 22;  // 0xFF10 .. 0xFF25

  // Raw bytes of 0x10-0x25; index = addr - 0x10.
  logic [7:0]   regs_q [0:NREGS-1];
  logic [7:0]   regs_d [0:NREGS-1];
  logic [3:0]   trig_q, trig_d;   // {noise, wave, sq2, sq1}
  logic         power_q, power_d;
  logic [127:0] wave_q, wave_d;
  logic [7:0]   rdata_q, rdata_d;

  logic [4:0]   widx_s;
  logic [6:0]   wbit_s;
  logic         in_regs_s;
  logic         in_wave_s;
  logic [7:0]   rd_mux_s;

  assign widx_s    = 5'(addr - 8'h10);
  assign wbit_s    = {addr[3:0], 3'b000};
  assign in_regs_s = (addr >= 8'h10) && (addr <= 8'h25) &&
                     (addr != 8'h15) && (addr != 8'h1F);
  assign in_wave_s = (addr[7:4] == 4'h3);

  // Next-state for registers, power, wave RAM and trigger pulses.
  always_comb begin
    regs_d  = regs_q;
    power_d = power_q;
    wave_d  = wave_q;
    trig_d  = 4'b0000;
    if (wr) begin
      if (addr == 8'h26) begin
        power_d = wdata[7];
        if (!wdata[7]) begin
          for (int i = 0; i < NREGS; i++) regs_d[i] = 8'h00;
        end else begin
          regs_d = regs_q;
        end
      end else if (in_wave_s) begin
        // even sample in the low nibble slot, odd sample just above it
        wave_d[wbit_s +: 4]         = wdata[7:4];
        wave_d[wbit_s + 7'd4 +: 4]  = wdata[3:0];
      end else if (power_q && in_regs_s) begin
        regs_d[widx_s] = (addr == 8'h23) ? (wdata & 8'hC0) : wdata;
        case (addr)
          8'h14:   trig_d[0] = wdata[7];
          8'h19:   trig_d[1] = wdata[7];
          8'h1E:   trig_d[2] = wdata[7];
          8'h23:   trig_d[3] = wdata[7];
          default: trig_d    = 4'b0000;
        endcase
      end else begin
        regs_d = regs_q;
      end
    end else begin
      regs_d = regs_q;
    end
  end

  // Read mux: stored bits ORed with the unreadable-bit mask (pre-write value).
  always_comb begin
    rd_mux_s = 8'hFF;
    if (in_wave_s) begin
      rd_mux_s = {wave_q[wbit_s +: 4], wave_q[wbit_s + 7'd4 +: 4]};
    end else begin
      case (addr)
        8'h10:   rd_mux_s = regs_q[0]  | 8'h80;
        8'h11:   rd_mux_s = regs_q[1]  | 8'h3F;
        8'h12:   rd_mux_s = regs_q[2];
        8'h14:   rd_mux_s = regs_q[4]  | 8'hBF;
        8'h16:   rd_mux_s = regs_q[6]  | 8'h3F;
        8'h17:   rd_mux_s = regs_q[7];
        8'h19:   rd_mux_s = regs_q[9]  | 8'hBF;
        8'h1A:   rd_mux_s = regs_q[10] | 8'h7F;
        8'h1C:   rd_mux_s = regs_q[12] | 8'h9F;
        8'h1E:   rd_mux_s = regs_q[14] | 8'hBF;
        8'h21:   rd_mux_s = regs_q[17];
        8'h22:   rd_mux_s = regs_q[18];
        8'h23:   rd_mux_s = regs_q[19] | 8'hBF;
        8'h24:   rd_mux_s = regs_q[20];
        8'h25:   rd_mux_s = regs_q[21];
        8'h26:   rd_mux_s = {power_q, 3'b111, ch_on};
        default: rd_mux_s = 8'hFF;
      endcase
    end
  end

  // Read data is captured on a read strobe and held otherwise.
  always_comb begin
    if (rd) begin
      rdata_d = rd_mux_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State registers; reset clears everything except power, which comes up on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'h00;
      trig_q  <= 4'b0000;
      power_q <= 1'b1;
      wave_q  <= 128'd0;
      rdata_q <= 8'h00;
    end else begin
      regs_q  <= regs_d;
      trig_q  <= trig_d;
      power_q <= power_d;
      wave_q  <= wave_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

  assign sq1_swpPd     = regs_q[0][6:4];
  assign sq1_negate    = regs_q[0][3];
  assign sq1_shift     = regs_q[0][2:0];
  assign sq1_duty      = regs_q[1][7:6];
  assign sq1_lenLoad   = regs_q[1][5:0];
  assign sq1_startVol  = regs_q[2][7:4];
  assign sq1_envAdd    = regs_q[2][3];
  assign sq1_period    = regs_q[2][2:0];
  assign sq1_freq      = {regs_q[4][2:0], regs_q[3]};
  assign sq1_lenEnable = regs_q[4][6];
  assign sq1_trig      = trig_q[0];

  assign sq2_duty      = regs_q[6][7:6];
  assign sq2_lenLoad   = regs_q[6][5:0];
  assign sq2_startVol  = regs_q[7][7:4];
  assign sq2_envAdd    = regs_q[7][3];
  assign sq2_period    = regs_q[7][2:0];
  assign sq2_freq      = {regs_q[9][2:0], regs_q[8]};
  assign sq2_lenEnable = regs_q[9][6];
  assign sq2_trig      = trig_q[1];

  assign w_enable      = regs_q[10][7];
  assign w_lenLoad     = regs_q[11][5:0];
  assign w_vol         = regs_q[12][6:5];
  assign w_freq        = {regs_q[14][2:0], regs_q[13]};
  assign w_lenEnable   = regs_q[14][6];
  assign w_trig        = trig_q[2];

  assign n_lenLoad     = regs_q[16][5:0];
  assign n_startVol    = regs_q[17][7:4];
  assign n_envAdd      = regs_q[17][3];
  assign n_period      = regs_q[17][2:0];
  assign n_clkShift    = regs_q[18][7:4];
  assign n_widthMode   = regs_q[18][3];
  assign n_divisor     = regs_q[18][2:0];
  assign n_lenEnable   = regs_q[19][6];
  assign n_trig        = trig_q[3];

  assign nr50          = regs_q[20];
  assign nr51          = regs_q[21];
  assign wave_table    = wave_q;

endmodule

// File: tb/tb_apu_reg_file.sv
// Directed bench for apu_reg_file: a write/read-back vector table plus
// hand-written sequences for triggers, power-off, same-cycle rd/wr and reset.
module tb_apu_reg_file;

  logic         clk, rst, wr, rd;
  logic [7:0]   addr, wdata, rdata;
  logic [3:0]   ch_on;
  logic [2:0]   sq1_swpPd, sq1_shift, sq1_period, sq2_period, n_period, n_divisor;
  logic         sq1_negate, sq1_envAdd, sq1_lenEnable, sq1_trig;
  logic [1:0]   sq1_duty, sq2_duty, w_vol;
  logic [5:0]   sq1_lenLoad, sq2_lenLoad, w_lenLoad, n_lenLoad;
  logic [3:0]   sq1_startVol, sq2_startVol, n_startVol, n_clkShift;
  logic [10:0]  sq1_freq, sq2_freq, w_freq;
  logic         sq2_envAdd, sq2_lenEnable, sq2_trig;
  logic         w_enable, w_lenEnable, w_trig;
  logic         n_envAdd, n_widthMode, n_lenEnable, n_trig;
  logic [7:0]   nr50, nr51;
  logic [127:0] wave_table;

  int checks = 0;
  int errors = 0;

  apu_reg_file dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ch_on(ch_on),
    .sq1_swpPd(sq1_swpPd), .sq1_negate(sq1_negate), .sq1_shift(sq1_shift),
    .sq1_duty(sq1_duty), .sq1_lenLoad(sq1_lenLoad), .sq1_startVol(sq1_startVol),
    .sq1_envAdd(sq1_envAdd), .sq1_period(sq1_period), .sq1_freq(sq1_freq),
    .sq1_lenEnable(sq1_lenEnable), .sq1_trig(sq1_trig),
    .sq2_duty(sq2_duty), .sq2_lenLoad(sq2_lenLoad), .sq2_startVol(sq2_startVol),
    .sq2_envAdd(sq2_envAdd), .sq2_period(sq2_period), .sq2_freq(sq2_freq),
    .sq2_lenEnable(sq2_lenEnable), .sq2_trig(sq2_trig),
    .w_enable(w_enable), .w_vol(w_vol), .w_lenLoad(w_lenLoad), .w_freq(w_freq),
    .w_lenEnable(w_lenEnable), .w_trig(w_trig),
    .n_lenLoad(n_lenLoad), .n_startVol(n_startVol), .n_envAdd(n_envAdd),
    .n_period(n_period), .n_clkShift(n_clkShift), .n_widthMode(n_widthMode),
    .n_divisor(n_divisor), .n_lenEnable(n_lenEnable), .n_trig(n_trig),
    .nr50(nr50), .nr51(nr51), .wave_table(wave_table)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [0:16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [7:0] v);
    @(negedge clk);
    rd = 1'b1; addr = a;
    @(negedge clk);
    rd = 1'b0;
    v = rdata;
  endtask

  logic [7:0] rv;

  initial begin
    vecs[0]  = '{8'h10, 8'h7F, 8'hFF};
    vecs[1]  = '{8'h11, 8'h85, 8'hBF};
    vecs[2]  = '{8'h12, 8'hA3, 8'hA3};
    vecs[3]  = '{8'h13, 8'h12, 8'hFF};
    vecs[4]  = '{8'h14, 8'h05, 8'hBF};
    vecs[5]  = '{8'h16, 8'hC0, 8'hFF};
    vecs[6]  = '{8'h1A, 8'h00, 8'h7F};
    vecs[7]  = '{8'h1B, 8'h2A, 8'hFF};
    vecs[8]  = '{8'h1C, 8'h40, 8'hDF};
    vecs[9]  = '{8'h20, 8'h3F, 8'hFF};
    vecs[10] = '{8'h21, 8'h3C, 8'h3C};
    vecs[11] = '{8'h22, 8'hA5, 8'hA5};
    vecs[12] = '{8'h23, 8'h40, 8'hFF};
    vecs[13] = '{8'h24, 8'h77, 8'h77};
    vecs[14] = '{8'h25, 8'h5A, 8'h5A};
    vecs[15] = '{8'h15, 8'h12, 8'hFF};
    vecs[16] = '{8'h2A, 8'h00, 8'hFF};

    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = 8'h00; wdata = 8'h00; ch_on = 4'b0000;
    #12;
    chk("reset_rdata", rdata, 8'h00);
    chk("reset_nr50", nr50, 8'h00);
    chk("reset_wave", wave_table, 128'd0);
    chk("reset_trig", {sq1_trig, sq2_trig, w_trig, n_trig}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    do_read(8'h26, rv);
    chk("reset_power_nr52", rv, 8'hF0);

    // table: write each register then read it back through the mask
    for (int i = 0; i < 17; i++) begin
      do_write(vecs[i].a, vecs[i].d);
      do_read(vecs[i].a, rv);
      chk($sformatf("readback_%0h", vecs[i].a), rv, vecs[i].exp_rd);
    end

    chk("sq1_nr10_fields", {sq1_swpPd, sq1_negate, sq1_shift}, 7'h7F);
    chk("sq1_nr11_fields", {sq1_duty, sq1_lenLoad}, 8'h85);
    chk("sq1_nr12_fields", {sq1_startVol, sq1_envAdd, sq1_period}, 8'hA3);
    chk("sq1_freq_tab", sq1_freq, 11'h512);
    chk("sq2_duty", sq2_duty, 2'd3);
    chk("w_fields", {w_enable, w_vol, w_lenLoad}, 9'b0_10_101010);
    chk("n_nr41_nr42", {n_lenLoad, n_startVol, n_envAdd, n_period}, 14'b111111_0011_1_100);
    chk("n_nr43", {n_clkShift, n_widthMode, n_divisor}, 8'hA5);
    chk("n_lenEnable", n_lenEnable, 1'b1);
    chk("nr51", nr51, 8'h5A);
    chk("no_trig_tab", {sq1_trig, sq2_trig, w_trig, n_trig}, 4'b0000);

    // trigger on NR14 with freq low byte set first
    do_write(8'h13, 8'h50);
    chk("sq1_trig_before", sq1_trig, 1'b0);
    do_write(8'h14, 8'h87);
    chk("sq1_freq_trig", sq1_freq, 11'h750);
    chk("sq1_lenEnable_trig", sq1_lenEnable, 1'b0);
    chk("sq1_trig_pulse", sq1_trig, 1'b1);
    @(negedge clk);
    chk("sq1_trig_one_cycle", sq1_trig, 1'b0);

    // back-to-back NR24 triggers: one pulse per write
    @(negedge clk);
    wr = 1'b1; addr = 8'h19; wdata = 8'h80;
    @(negedge clk);
    chk("sq2_trig_first", sq2_trig, 1'b1);
    @(negedge clk);
    wr = 1'b0;
    chk("sq2_trig_second", sq2_trig, 1'b1);
    @(negedge clk);
    chk("sq2_trig_end", sq2_trig, 1'b0);

    // NR34 with bit7 clear: fields only
    do_write(8'h1E, 8'h47);
    chk("w_trig_no", w_trig, 1'b0);
    chk("w_freq_lenen", {w_lenEnable, w_freq}, 12'hF00);

    // wave RAM
    do_write(8'h30, 8'h1F);
    chk("wave_byte0", wave_table[7:0], 8'hF1);
    do_read(8'h30, rv);
    chk("wave_rd30", rv, 8'h1F);
    do_read(8'h15, rv);
    chk("rd15_unmapped", rv, 8'hFF);
    do_write(8'h3F, 8'hAB);
    chk("wave_byte15", wave_table[127:120], 8'hBA);
    do_read(8'h3F, rv);
    chk("wave_rd3f", rv, 8'hAB);

    // same-cycle read and write: old value returned
    @(negedge clk);
    wr = 1'b1; rd = 1'b1; addr = 8'h24; wdata = 8'h11;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    chk("rdwr_pre_value", rdata, 8'h77);
    chk("rdwr_nr50_new", nr50, 8'h11);

    // power off
    ch_on = 4'b0101;
    do_write(8'h26, 8'h00);
    chk("off_sq1_freq", sq1_freq, 11'h000);
    chk("off_nr50", nr50, 8'h00);
    chk("off_n_clk", {n_clkShift, n_widthMode, n_divisor}, 8'h00);
    chk("off_no_trig", {sq1_trig, sq2_trig, w_trig, n_trig}, 4'b0000);
    do_write(8'h12, 8'hF0);
    chk("off_startVol", sq1_startVol, 4'h0);
    do_read(8'h26, rv);
    chk("off_nr52", rv, 8'h75);
    do_write(8'h31, 8'h5C);
    do_read(8'h31, rv);
    chk("off_wave_rw", rv, 8'h5C);
    do_write(8'h26, 8'h80);
    do_read(8'h26, rv);
    chk("on_nr52", rv, 8'hF5);
    do_read(8'h12, rv);
    chk("on_nr12_still0", rv, 8'h00);
    do_write(8'h12, 8'hF0);
    chk("on_startVol", sq1_startVol, 4'hF);

    // reset pulsed mid-stream with a trigger write in flight
    do_write(8'h24, 8'h77);
    do_read(8'h24, rv);
    chk("pre_rst_rdata", rv, 8'h77);
    @(negedge clk);
    wr = 1'b1; addr = 8'h14; wdata = 8'h80; rst = 1'b1;
    #1;
    chk("rst_nr50", nr50, 8'h00);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_wave", wave_table, 128'd0);
    @(negedge clk);
    chk("rst_no_trig", sq1_trig, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    wr = 1'b0;
    chk("post_rst_trig", sq1_trig, 1'b1);
    do_read(8'h26, rv);
    chk("post_rst_power", rv, 8'hF5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
